bp_be_scoreboard_bypass: RTL and testbench
==========================================

BP_BE_SCOREBOARD_BYPASS -- requirements
Module: bp_be_scoreboard_bypass

Interface
REQ-001 Parameter fwd_els_p, no default ("inv" rejected at elaboration), number of forwarding candidates; index 0 is youngest.
REQ-002 Parameter num_rs_p, default 2, number of source operands per dispatch (3 for fused ops).
REQ-003 Parameter num_wb_p, default 1, number of scoreboard-clear (writeback) ports.
REQ-004 Parameter enable_p, default 1; when 0, bypass is passthrough and stall_o is tied 0.
REQ-005 clk_i  in  1  single clock; all state updates on rising edge.
REQ-006 reset_i  in  1  asynchronous, active-high reset.
REQ-007 dispatch_v_i  in  1  instruction presented for issue.
REQ-008 rs_v_i  in  num_rs_p  per-operand read enable.
REQ-009 rs_addr_i  in  num_rs_p x 5  source register addresses.
REQ-010 rs_data_i  in  num_rs_p x 64  regfile read data.
REQ-011 rd_v_i / rd_addr_i  in  1 / 5  dispatched instruction writes rd.
REQ-012 fwd_rd_v_i / fwd_rd_addr_i / fwd_rd_i  in  fwd_els_p / fwd_els_p x 5 / fwd_els_p x 64  forwarding candidates.
REQ-013 wb_v_i / wb_addr_i  in  num_wb_p / num_wb_p x 5  architectural writes completing (clear busy).
REQ-014 flush_i  in  1  squash all in-flight writers.
REQ-015 stall_o  out  1  dispatch blocked by hazard this cycle.
REQ-016 bypass_rs_o  out  num_rs_p x 64  youngest valid operand data.
REQ-017 hazard_cnt_o  out  16  saturating count of stalled dispatch cycles.

Function
REQ-018 Block SHALL hold a 32-entry busy vector; entry 0 SHALL read 0 at all times.
REQ-019 Operand i bypass SHALL select the lowest-index fwd entry with fwd_rd_v_i, matching address, rs_v_i[i] and rs_addr_i[i]!=0; else rs_data_i[i]; purely combinational, zero latency.
REQ-020 Operand i SHALL be hazardous when rs_v_i[i], busy[rs_addr_i[i]] and no fwd hit for that operand.
REQ-021 WAW hazard SHALL be raised when rd_v_i, rd_addr_i!=0 and busy[rd_addr_i].
REQ-022 stall_o SHALL equal dispatch_v_i AND (any operand hazard OR WAW hazard), combinational.
REQ-023 Accepted dispatch (dispatch_v_i & ~stall_o) with rd_v_i and rd_addr_i!=0 SHALL set busy[rd_addr_i] at the next edge.
REQ-024 Each wb_v_i[j] SHALL clear busy[wb_addr_i[j]] at the next edge; duplicate clears harmless.
REQ-025 Same-cycle set and clear of one register SHALL leave it set (dispatch is younger).
REQ-026 flush_i SHALL clear all busy bits at the next edge, overriding same-cycle sets and clears; stall_o is not masked by flush_i.
REQ-027 hazard_cnt_o SHALL increment by 1 each cycle stall_o=1, saturating at 16'hFFFF; not cleared by flush_i.
REQ-028 Busy state SHALL not bypass same-cycle wb clears combinationally; a completing value must be presented on a fwd port to avoid the stall.

Reset
REQ-029 reset_i assertion SHALL asynchronously clear busy vector and hazard_cnt_o to 0; stall_o then depends only on inputs and reads 0 for any address.
REQ-030 Reset mid-operation SHALL discard all pending busy state; no set/clear from the reset cycle SHALL survive.

Structure
REQ-031 Register address width (5), data width (64) and register count (32) SHALL come from bp_be_rv64_pkg constants; no new typedefs.
REQ-032 Per-operand select SHALL be one sub-module, bp_be_bypass_operand (priority one-hot encode + one-hot mux), instantiated num_rs_p times.
REQ-033 Parameter checks (fwd_els_p>0, num_rs_p>=1, num_wb_p>=1) SHALL be elaboration-time assertions.

Verification
REQ-034 Dispatch rd=x5 accepted; next cycle rs1=x5, no fwd -> stall_o=1, hazard_cnt_o increments to 1.
REQ-035 busy[x5]=1, fwd[1]={v,x5,0xAA}, fwd[0]={v,x5,0xBB}, rs1=x5 -> stall_o=0, bypass_rs_o[0]=0xBB.
REQ-036 rs1=x0, fwd[0]={v,x0,0x55}, rs_data=0 -> bypass 0, stall_o=0; dispatch rd=x0 never sets busy.
REQ-037 busy[x7]=1, same cycle wb x7 and accepted dispatch rd=x7 -> busy[x7]=1 next cycle; with flush_i also high -> busy[x7]=0.
REQ-038 Hold stall 65540 cycles -> hazard_cnt_o=0xFFFF; assert reset_i mid-cycle -> counter and busy 0 before next edge.
REQ-039 enable_p=0 build: busy[x3] set, rs1=x3 -> stall_o=0, bypass_rs_o[0]=rs_data_i[0].

Source files
------------

// File: rtl/bp_be_rv64_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bp_be_rv64_pkg
// Description : RV64 architectural constants shared by the backend blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package bp_be_rv64_pkg;

    localparam int c_REG_ADDR_WIDTH = 5;
    localparam int c_DWORD_WIDTH    = 64;
    localparam int c_RF_ELS         = 32;

endpackage : bp_be_rv64_pkg
`default_nettype wire

// File: rtl/bp_be_bypass_operand.sv
`default_nettype none
// ============================================================================
// Module      : bp_be_bypass_operand
// Description : Selects one source operand from the youngest matching
//               forwarding candidate, or the regfile value when none match.
// Revision    : 1.0 - initial release
// ============================================================================
module bp_be_bypass_operand
    import bp_be_rv64_pkg::*;
#(
    parameter int fwd_els_p = 1
) (
    input  logic                                        rs_v_i,
    input  logic [c_REG_ADDR_WIDTH-1:0]                 rs_addr_i,
    input  logic [c_DWORD_WIDTH-1:0]                    rs_data_i,
    input  logic [fwd_els_p-1:0]                        fwd_rd_v_i,
    input  logic [fwd_els_p-1:0][c_REG_ADDR_WIDTH-1:0]  fwd_rd_addr_i,
    input  logic [fwd_els_p-1:0][c_DWORD_WIDTH-1:0]     fwd_rd_i,
    output logic                                        hit_o,
    output logic [c_DWORD_WIDTH-1:0]                    data_o
);

    logic [fwd_els_p-1:0]       w_match;
    logic [fwd_els_p-1:0]       w_sel_oh;
    logic                       w_taken;
    logic [c_DWORD_WIDTH-1:0]   w_fwd_data;

    // x0 is hardwired zero, so it never takes a forwarded value
    always_comb begin
        w_match = '0;
        for (int k = 0; k < fwd_els_p; k++) begin
            w_match[k] = fwd_rd_v_i[k] & rs_v_i & (rs_addr_i != '0)
                       & (fwd_rd_addr_i[k] == rs_addr_i);
        end
    end

    always_comb begin
        w_sel_oh = '0;
        w_taken  = 1'b0;
        for (int k = 0; k < fwd_els_p; k++) begin
            w_sel_oh[k] = w_match[k] & ~w_taken;
            w_taken     = w_taken | w_match[k];
        end
    end

    always_comb begin
        w_fwd_data = '0;
        for (int k = 0; k < fwd_els_p; k++) begin
            w_fwd_data = w_fwd_data | (fwd_rd_i[k] & {c_DWORD_WIDTH{w_sel_oh[k]}});
        end
    end

    assign hit_o  = |w_match;
    assign data_o = hit_o ? w_fwd_data : rs_data_i;

endmodule : bp_be_bypass_operand
`default_nettype wire

// File: rtl/bp_be_scoreboard_bypass.sv
`default_nettype none
// ============================================================================
// Module      : bp_be_scoreboard_bypass
// Description : Register busy scoreboard with operand forwarding, RAW/WAW
//               dispatch stall and a saturating stall-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module bp_be_scoreboard_bypass
    import bp_be_rv64_pkg::*;
#(
    parameter int fwd_els_p = 0,
    parameter int num_rs_p  = 2,
    parameter int num_wb_p  = 1,
    parameter bit enable_p  = 1'b1
) (
    input  logic                                        clk_i,
    input  logic                                        reset_i,
    input  logic                                        dispatch_v_i,
    input  logic [num_rs_p-1:0]                         rs_v_i,
    input  logic [num_rs_p-1:0][c_REG_ADDR_WIDTH-1:0]   rs_addr_i,
    input  logic [num_rs_p-1:0][c_DWORD_WIDTH-1:0]      rs_data_i,
    input  logic                                        rd_v_i,
    input  logic [c_REG_ADDR_WIDTH-1:0]                 rd_addr_i,
    input  logic [fwd_els_p-1:0]                        fwd_rd_v_i,
    input  logic [fwd_els_p-1:0][c_REG_ADDR_WIDTH-1:0]  fwd_rd_addr_i,
    input  logic [fwd_els_p-1:0][c_DWORD_WIDTH-1:0]     fwd_rd_i,
    input  logic [num_wb_p-1:0]                         wb_v_i,
    input  logic [num_wb_p-1:0][c_REG_ADDR_WIDTH-1:0]   wb_addr_i,
    input  logic                                        flush_i,
    output logic                                        stall_o,
    output logic [num_rs_p-1:0][c_DWORD_WIDTH-1:0]      bypass_rs_o,
    output logic [15:0]                                 hazard_cnt_o
);

    localparam int c_CNT_WIDTH = 16;

    if (fwd_els_p < 1) begin : g_chk_fwd_els
        $error("fwd_els_p has no default and must be set to at least 1");
    end
    if (num_rs_p < 1) begin : g_chk_num_rs
        $error("num_rs_p must be at least 1");
    end
    if (num_wb_p < 1) begin : g_chk_num_wb
        $error("num_wb_p must be at least 1");
    end

    logic [c_RF_ELS-1:0]                        busy_q, busy_d;
    logic [c_CNT_WIDTH-1:0]                     hazard_cnt_q, hazard_cnt_d;
    logic [num_rs_p-1:0]                        w_hit;
    logic [num_rs_p-1:0]                        w_op_hazard;
    logic [num_rs_p-1:0][c_DWORD_WIDTH-1:0]     w_fwd_data;
    logic                                       w_waw_hazard;
    logic                                       w_dispatch_accept;

    for (genvar i = 0; i < num_rs_p; i++) begin : g_operand
        bp_be_bypass_operand #(
            .fwd_els_p (fwd_els_p)
        ) u_operand (
            .rs_v_i        (rs_v_i[i]),
            .rs_addr_i     (rs_addr_i[i]),
            .rs_data_i     (rs_data_i[i]),
            .fwd_rd_v_i    (fwd_rd_v_i),
            .fwd_rd_addr_i (fwd_rd_addr_i),
            .fwd_rd_i      (fwd_rd_i),
            .hit_o         (w_hit[i]),
            .data_o        (w_fwd_data[i])
        );
        assign bypass_rs_o[i] = enable_p ? w_fwd_data[i] : rs_data_i[i];
    end

    // busy_q reflects last edge only; a same-cycle writeback must arrive on a fwd port
    always_comb begin
        w_op_hazard = '0;
        for (int i = 0; i < num_rs_p; i++) begin
            w_op_hazard[i] = rs_v_i[i] & busy_q[rs_addr_i[i]] & ~w_hit[i];
        end
    end

    assign w_waw_hazard      = rd_v_i & (rd_addr_i != '0) & busy_q[rd_addr_i];
    assign stall_o           = enable_p & dispatch_v_i & ((|w_op_hazard) | w_waw_hazard);
    assign w_dispatch_accept = dispatch_v_i & ~stall_o;

    // Ordering gives priority: clears, then the younger dispatch set, then flush
    always_comb begin
        busy_d = busy_q;
        for (int j = 0; j < num_wb_p; j++) begin
            if (wb_v_i[j]) begin
                busy_d[wb_addr_i[j]] = 1'b0;
            end
        end
        if (w_dispatch_accept && rd_v_i && (rd_addr_i != '0)) begin
            busy_d[rd_addr_i] = 1'b1;
        end
        if (flush_i) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        hazard_cnt_d = hazard_cnt_q;
        if (stall_o && (hazard_cnt_q != '1)) begin
            hazard_cnt_d = hazard_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            busy_q       <= '0;
            hazard_cnt_q <= '0;
        end else begin
            busy_q       <= busy_d;
            hazard_cnt_q <= hazard_cnt_d;
        end
    end

    assign hazard_cnt_o = hazard_cnt_q;

endmodule : bp_be_scoreboard_bypass
`default_nettype wire

// File: tb/tb_bp_be_scoreboard_bypass.sv
`default_nettype none
// ============================================================================
// Module      : tb_bp_be_scoreboard_bypass
// Description : Directed bench with a register-level reference model for the
//               scoreboard/bypass block plus a passthrough (enable_p=0) build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bp_be_scoreboard_bypass;

    localparam int FWD = 2;
    localparam int NRS = 2;
    localparam int NWB = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                       dispatch_v;
    logic [NRS-1:0]             rs_v;
    logic [NRS-1:0][4:0]        rs_addr;
    logic [NRS-1:0][63:0]       rs_data;
    logic                       rd_v;
    logic [4:0]                 rd_addr;
    logic [FWD-1:0]             fwd_v;
    logic [FWD-1:0][4:0]        fwd_addr;
    logic [FWD-1:0][63:0]       fwd_data;
    logic [NWB-1:0]             wb_v;
    logic [NWB-1:0][4:0]        wb_addr;
    logic                       flush;

    logic                       stall, stall_n;
    logic [NRS-1:0][63:0]       bypass, bypass_n;
    logic [15:0]                cnt, cnt_n;

    bp_be_scoreboard_bypass #(
        .fwd_els_p (FWD), .num_rs_p (NRS), .num_wb_p (NWB), .enable_p (1'b1)
    ) dut (
        .clk_i (clk), .reset_i (rst), .dispatch_v_i (dispatch_v),
        .rs_v_i (rs_v), .rs_addr_i (rs_addr), .rs_data_i (rs_data),
        .rd_v_i (rd_v), .rd_addr_i (rd_addr),
        .fwd_rd_v_i (fwd_v), .fwd_rd_addr_i (fwd_addr), .fwd_rd_i (fwd_data),
        .wb_v_i (wb_v), .wb_addr_i (wb_addr), .flush_i (flush),
        .stall_o (stall), .bypass_rs_o (bypass), .hazard_cnt_o (cnt)
    );

    bp_be_scoreboard_bypass #(
        .fwd_els_p (FWD), .num_rs_p (NRS), .num_wb_p (NWB), .enable_p (1'b0)
    ) dut_nobyp (
        .clk_i (clk), .reset_i (rst), .dispatch_v_i (dispatch_v),
        .rs_v_i (rs_v), .rs_addr_i (rs_addr), .rs_data_i (rs_data),
        .rd_v_i (rd_v), .rd_addr_i (rd_addr),
        .fwd_rd_v_i (fwd_v), .fwd_rd_addr_i (fwd_addr), .fwd_rd_i (fwd_data),
        .wb_v_i (wb_v), .wb_addr_i (wb_addr), .flush_i (flush),
        .stall_o (stall_n), .bypass_rs_o (bypass_n), .hazard_cnt_o (cnt_n)
    );

    int vectors = 0;
    int errors  = 0;
    bit chk_en  = 1'b0;

    // Reference model: set of busy architectural registers and a stall tally
    bit          m_busy [32];
    int unsigned m_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] exp_operand(input int i, output bit hit);
        logic [63:0] v;
        hit = 1'b0;
        v   = rs_data[i];
        if (rs_v[i] && rs_addr[i] != 5'd0) begin
            for (int k = 0; k < FWD; k++) begin
                if (!hit && fwd_v[k] && fwd_addr[k] == rs_addr[i]) begin
                    hit = 1'b1;
                    v   = fwd_data[k];
                end
            end
        end
        return v;
    endfunction

    function automatic bit exp_stall();
        bit          hazard;
        bit          hit;
        logic [63:0] unused_v;
        hazard = 1'b0;
        for (int i = 0; i < NRS; i++) begin
            unused_v = exp_operand(i, hit);
            if (rs_v[i] && m_busy[rs_addr[i]] && !hit) hazard = 1'b1;
        end
        if (rd_v && rd_addr != 5'd0 && m_busy[rd_addr]) hazard = 1'b1;
        return dispatch_v && hazard;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            foreach (m_busy[r]) m_busy[r] = 1'b0;
            m_cnt = 0;
        end else begin
            bit st;
            st = exp_stall();
            if (st && m_cnt < 65535) m_cnt = m_cnt + 1;
            if (flush) begin
                foreach (m_busy[r]) m_busy[r] = 1'b0;
            end else begin
                for (int j = 0; j < NWB; j++) if (wb_v[j]) m_busy[wb_addr[j]] = 1'b0;
                if (dispatch_v && !st && rd_v && rd_addr != 5'd0) m_busy[rd_addr] = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit hit;
            chk("stall", {63'd0, stall}, {63'd0, exp_stall()});
            for (int i = 0; i < NRS; i++) begin
                chk("bypass", bypass[i], exp_operand(i, hit));
                chk("nobyp_bypass", bypass_n[i], rs_data[i]);
            end
            chk("hazard_cnt", {48'd0, cnt}, 64'(m_cnt));
            chk("nobyp_stall", {63'd0, stall_n}, 64'd0);
            chk("nobyp_cnt", {48'd0, cnt_n}, 64'd0);
        end
    end

    task automatic idle();
        dispatch_v = 1'b0; rs_v = '0; rs_addr = '0; rs_data = '0;
        rd_v = 1'b0; rd_addr = '0; fwd_v = '0; fwd_addr = '0; fwd_data = '0;
        wb_v = '0; wb_addr = '0; flush = 1'b0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_cnt", {48'd0, cnt}, 64'd0);
        chk("reset_stall", {63'd0, stall}, 64'd0);

        // RAW on x5 after dispatch writing x5
        nxt(); dispatch_v = 1; rd_v = 1; rd_addr = 5;
        @(negedge clk); chk("disp_x5", {63'd0, stall}, 64'd0);
        nxt(); dispatch_v = 1; rs_v[0] = 1; rs_addr[0] = 5;
        @(negedge clk); chk("raw_x5", {63'd0, stall}, 64'd1);
        nxt();
        @(negedge clk); chk("cnt_one", {48'd0, cnt}, 64'd1);

        // youngest forward wins
        nxt(); dispatch_v = 1; rs_v = 2'b11; rs_addr[0] = 5; rs_data[0] = 64'h1234;
        rs_addr[1] = 6; rs_data[1] = 64'h77;
        fwd_v = 2'b11; fwd_addr[1] = 5; fwd_data[1] = 64'hAA; fwd_addr[0] = 5; fwd_data[0] = 64'hBB;
        @(negedge clk);
        chk("fwd_stall", {63'd0, stall}, 64'd0);
        chk("fwd_young", bypass[0], 64'hBB);
        chk("fwd_rf", bypass[1], 64'h77);
        fwd_addr[0] = 4;
        #1 chk("fwd_older", bypass[0], 64'hAA);

        // x0 never forwards and never becomes busy
        nxt(); dispatch_v = 1; rs_v[0] = 1; rs_addr[0] = 0; fwd_v[0] = 1; fwd_data[0] = 64'h55;
        rd_v = 1; rd_addr = 0;
        @(negedge clk); chk("x0_byp", bypass[0], 64'd0);
        nxt(); dispatch_v = 1; rs_v[0] = 1; rs_addr[0] = 0; rd_v = 1; rd_addr = 0;
        @(negedge clk); chk("x0_waw", {63'd0, stall}, 64'd0);

        nxt(); dispatch_v = 1; rd_v = 1; rd_addr = 5;
        @(negedge clk); chk("waw_x5", {63'd0, stall}, 64'd1);

        // writeback versus dispatch on one register
        nxt(); dispatch_v = 1; rd_v = 1; rd_addr = 7;
        nxt(); dispatch_v = 1; rd_v = 1; rd_addr = 7; wb_v[0] = 1; wb_addr[0] = 7;
        @(negedge clk); chk("wb_no_comb", {63'd0, stall}, 64'd1);
        nxt(); dispatch_v = 1; rs_v[0] = 1; rs_addr[0] = 7;
        @(negedge clk); chk("wb_cleared", {63'd0, stall}, 64'd0);
        nxt(); dispatch_v = 1; rd_v = 1; rd_addr = 8; wb_v = 2'b11; wb_addr[0] = 8; wb_addr[1] = 8;
        nxt(); dispatch_v = 1; rs_v[0] = 1; rs_addr[0] = 8;
        @(negedge clk); chk("set_wins", {63'd0, stall}, 64'd1);
        nxt(); dispatch_v = 1; rd_v = 1; rd_addr = 9; wb_v[0] = 1; wb_addr[0] = 9; flush = 1;
        nxt(); dispatch_v = 1; rs_v = 2'b11; rs_addr[0] = 9; rs_addr[1] = 5;
        @(negedge clk); chk("flush_wins", {63'd0, stall}, 64'd0);

        // flush does not mask stall; passthrough build ignores busy x3
        nxt(); dispatch_v = 1; rd_v = 1; rd_addr = 3;
        nxt(); dispatch_v = 1; rs_v[0] = 1; rs_addr[0] = 3; rs_data[0] = 64'hC0FFEE; flush = 1;
        fwd_v[0] = 1; fwd_addr[0] = 3; fwd_data[0] = 64'hDEAD; fwd_addr[1] = 4; fwd_v[1] = 1;
        fwd_v[0] = 0;
        @(negedge clk);
        chk("flush_stall", {63'd0, stall}, 64'd1);
        chk("nobyp_x3_stall", {63'd0, stall_n}, 64'd0);
        chk("nobyp_x3_data", bypass_n[0], 64'hC0FFEE);

        // saturation
        nxt(); dispatch_v = 1; rd_v = 1; rd_addr = 10;
        nxt(); dispatch_v = 1; rs_v[0] = 1; rs_addr[0] = 10;
        repeat (65540) @(posedge clk);
        @(negedge clk); chk("cnt_sat", {48'd0, cnt}, 64'hFFFF);

        // asynchronous reset mid-cycle, pending dispatch discarded
        @(posedge clk);
        #2 rst = 1; rd_v = 1; rd_addr = 11;
        #1;
        chk("async_cnt", {48'd0, cnt}, 64'd0);
        chk("async_stall", {63'd0, stall}, 64'd0);
        @(posedge clk);
        #1 rst = 0; idle();
        nxt(); dispatch_v = 1; rs_v = 2'b11; rs_addr[0] = 11; rs_addr[1] = 10;
        @(negedge clk); chk("post_reset", {63'd0, stall}, 64'd0);

        nxt();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule : tb_bp_be_scoreboard_bypass
`default_nettype wire
